// File: rtl/sum_accumulator.sv
// sum_accumulator: sums BURST adder results {carry,sum} into an ACC_W-bit total offered on valid/ready.
// Optional build macro SUM_ACC_SAT_EN: saturate at 2^ACC_W-1 on overflow instead of wrapping.
module sum_accumulator #(
    parameter int ACC_W = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [3:0]       in_sum,
    input  logic             in_carry,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic [7:0]       beat_cnt
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam logic [7:0] LAST_BEAT = 8'(BURST - 1);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [ACC_W-1:0] operand;
    logic [ACC_W:0]   sum_wide;
    logic             accept;

    assign operand  = ACC_W'({in_carry, in_sum});
    assign sum_wide = {1'b0, acc_q} + {1'b0, operand};
    assign accept   = in_valid & in_ready_q;

    always_comb begin
        // NOTE: every _d gets a default first, so no path through this block can infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        cnt_d = cnt_q + 8'd1;
                        if (sum_wide[ACC_W]) begin
                            ovf_d = 1'b1;
                        end
`ifdef SUM_ACC_SAT_EN
                        acc_d = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
`else
                        acc_d = sum_wide[ACC_W-1:0];
`endif
                        if (cnt_q == LAST_BEAT) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end

        // Handshake outputs are registered copies of the next state, so they never follow out_ready combinationally.
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and active-high; state uses non-blocking assignments only.
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: table-driven bursts with a result scoreboard, plus clear/reset/overflow sequences.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst, clear, in_valid, out_ready;
    logic [3:0] in_sum;
    logic       in_carry;
    logic       in_ready, out_valid, out_ovf;
    logic [7:0] out_sum, beat_cnt;

    logic       in_valid_b, out_ready_b;
    logic       in_ready_b, out_valid_b, out_ovf_b;
    logic [7:0] out_sum_b, beat_cnt_b;

    always #5 clk = ~clk;

    sum_accumulator #(.ACC_W(8), .BURST(4)) u_dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_sum(in_sum), .in_carry(in_carry), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_ovf(out_ovf), .beat_cnt(beat_cnt)
    );

    sum_accumulator #(.ACC_W(8), .BURST(16)) u_dut16 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid_b), .in_sum(in_sum), .in_carry(in_carry), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_sum(out_sum_b),
        .out_ovf(out_ovf_b), .beat_cnt(beat_cnt_b)
    );

    typedef struct {
        int op[4];
        int gap;
        int exp_sum;
        int exp_ovf;
    } vec_t;

    typedef struct {
        int sum;
        int ovf;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int op);
        logic [4:0] op5;
        op5      = 5'(op);
        in_sum   = op5[3:0];
        in_carry = op5[4];
    endtask

    // One BURST=4 transfer; optionally stall in HOLD with in_valid high, then optionally release.
    task automatic run_vec(input vec_t v, input int stall, input bit release_out);
        exp_t e;
        int   waited;
        sb.push_back('{sum: v.exp_sum, ovf: v.exp_ovf});
        check("in_ready_idle", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            set_op(v.op[i]);
            tick();
            in_valid = 1'b0;
            check("beat_cnt", beat_cnt, i + 1);
            if (i < 3) begin
                check("out_valid_mid", out_valid, 0);
                if (v.gap != 0) begin
                    tick();
                    check("beat_cnt_gap", beat_cnt, i + 1);
                end
            end
        end
        check("out_valid_latency", out_valid, 1);
        waited = 0;
        while (!out_valid && waited < 16) begin
            tick();
            waited++;
        end
        if (!out_valid) check("out_valid_timeout", out_valid, 1);
        e = sb.pop_front();
        check("out_sum", out_sum, e.sum);
        check("out_ovf", out_ovf, e.ovf);
        check("in_ready_hold", in_ready, 0);
        in_valid = 1'b1;
        set_op(7);
        for (int s = 0; s < stall; s++) begin
            tick();
            check("hold_sum", out_sum, e.sum);
            check("hold_cnt", beat_cnt, 4);
            check("hold_valid", out_valid, 1);
        end
        if (release_out) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("rel_valid", out_valid, 0);
            check("rel_ready", in_ready, 1);
            check("rel_sum", out_sum, 0);
            check("rel_cnt", beat_cnt, 0);
            check("rel_ovf", out_ovf, 0);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{op: '{10, 2, 31, 16}, gap: 0, exp_sum: 59,  exp_ovf: 0};
        vecs[1] = '{op: '{5, 5, 5, 5},    gap: 1, exp_sum: 20,  exp_ovf: 0};
        vecs[2] = '{op: '{0, 0, 0, 0},    gap: 0, exp_sum: 0,   exp_ovf: 0};
        vecs[3] = '{op: '{31, 31, 31, 31},gap: 1, exp_sum: 124, exp_ovf: 0};
        vecs[4] = '{op: '{1, 2, 3, 4},    gap: 0, exp_sum: 10,  exp_ovf: 0};
        vecs[5] = '{op: '{16, 0, 16, 0},  gap: 0, exp_sum: 32,  exp_ovf: 0};

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_valid_b = 1'b0; out_ready_b = 1'b0; set_op(0);
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], (i == 0) ? 5 : 1, 1'b1);

        // Clear after two beats, coinciding with a valid beat of 7 that must be dropped.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; set_op(1); tick();
        end
        check("pre_clear_cnt", beat_cnt, 2);
        clear = 1'b1; set_op(7); tick();
        clear = 1'b0; in_valid = 1'b0;
        check("clear_cnt", beat_cnt, 0);
        check("clear_sum", out_sum, 0);
        check("clear_ready", in_ready, 1);
        run_vec('{op: '{1, 1, 1, 1}, gap: 0, exp_sum: 4, exp_ovf: 0}, 0, 1'b1);

        // Reset while holding 59.
        run_vec(vecs[0], 2, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("hrst_in_ready", in_ready, 1);
        check("hrst_out_valid", out_valid, 0);
        check("hrst_out_sum", out_sum, 0);
        check("hrst_out_ovf", out_ovf, 0);
        check("hrst_beat_cnt", beat_cnt, 0);
        run_vec(vecs[4], 0, 1'b1);

        // BURST=16 of operand 31: total 496 overflows an 8-bit accumulator at the 9th beat.
        set_op(31);
        in_valid_b = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 8) check("b16_ovf_before", out_ovf_b, 0);
            if (i == 9) check("b16_ovf_after", out_ovf_b, 1);
        end
        in_valid_b = 1'b0;
        check("b16_valid", out_valid_b, 1);
        check("b16_cnt", beat_cnt_b, 16);
`ifdef SUM_ACC_SAT_EN
        check("b16_sum", out_sum_b, 255);
`else
        check("b16_sum", out_sum_b, 240);
`endif
        check("b16_ovf", out_ovf_b, 1);
        out_ready_b = 1'b1; tick(); out_ready_b = 1'b0;
        check("b16_rel_valid", out_valid_b, 0);
        check("b16_rel_sum", out_sum_b, 0);
        check("b16_rel_ovf", out_ovf_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
